// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter granting one shared datapath resource to one of N requesters.
// Optional hold-time preemption is built when ARB_TIMEOUT_EN is defined.
module rr_bus_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] sel,
  output logic                 busy,
  output logic                 preempt
);

  localparam int SW = $clog2(N);

  generate
    if (N < 2 || N > 16 || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_param
      $error("rr_bus_arbiter: parameter out of legal range");
    end
  endgenerate

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_reg, state_next;
  logic [SW-1:0]  owner_reg, owner_next;
  logic [SW-1:0]  ptr_reg, ptr_next;
  logic [SW-1:0]  sel_reg, sel_next;
  logic [N-1:0]   gnt_reg, gnt_next;
  logic [SW-1:0]  owner_inc;
  logic [SW-1:0]  win;
  logic           found;
  logic           rel;
  logic [SW-1:0]  cand [N];

`ifdef ARB_TIMEOUT_EN
  logic [7:0]     hcnt_reg, hcnt_next;
  logic           preempt_reg, preempt_next;
  logic           hold_expired;

  assign hold_expired = (hcnt_reg == 8'(HOLD_MAX - 1));
`endif

  // cand[k] is the requester index examined k-th, counting from ptr with wrap below N
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cand
      logic [SW:0] sum;
      assign sum      = {1'b0, ptr_reg} + (SW+1)'(gi);
      assign cand[gi] = (sum >= (SW+1)'(N)) ? SW'(sum - (SW+1)'(N)) : sum[SW-1:0];
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[cand[k]]) begin
        found = 1'b1;
        win   = cand[k];
      end
    end
  end

  assign owner_inc = (owner_reg == SW'(N - 1)) ? '0 : owner_reg + SW'(1);

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    gnt_next   = gnt_reg;
    rel        = 1'b0;
`ifdef ARB_TIMEOUT_EN
    preempt_next = 1'b0;
    hcnt_next    = hcnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next    = GRANT;
          owner_next    = win;
          sel_next      = win;
          gnt_next      = '0;
          gnt_next[win] = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hcnt_next     = '0;
`endif
        end
      end
      GRANT: begin
        rel = !req[owner_reg];
`ifdef ARB_TIMEOUT_EN
        if (req[owner_reg] && hold_expired) begin
          rel          = 1'b1;
          preempt_next = 1'b1;
        end
        if (!rel) hcnt_next = hcnt_reg + 8'd1;
`endif
        // Releasing always passes through IDLE, giving the bus-turnaround cycle
        if (rel) begin
          state_next = IDLE;
          gnt_next   = '0;
          ptr_next   = owner_inc;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      ptr_reg   <= '0;
      sel_reg   <= '0;
      gnt_reg   <= '0;
`ifdef ARB_TIMEOUT_EN
      hcnt_reg    <= '0;
      preempt_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      gnt_reg   <= gnt_next;
`ifdef ARB_TIMEOUT_EN
      hcnt_reg    <= hcnt_next;
      preempt_reg <= preempt_next;
`endif
    end
  end

  assign gnt  = gnt_reg;
  assign sel  = sel_reg;
  assign busy = |gnt_reg;
`ifdef ARB_TIMEOUT_EN
  assign preempt = preempt_reg;
`else
  assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Directed plus random bench for rr_bus_arbiter (N=4, HOLD_MAX=8) against a
// behavioural model of the round-robin grant rules.
module tb_rr_bus_arbiter;

  localparam int N        = 4;
  localparam int HOLD_MAX = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       preempt;

  rr_bus_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: current owner (-1 when nobody holds), rotation start, last owner, hold cycles
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_hcnt  = 0;
  bit m_pre   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_sel   = 0;
    m_hcnt  = 0;
    m_pre   = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r);
    m_pre = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (r[i]) begin
          m_owner = i;
          m_sel   = i;
          m_hcnt  = 0;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (TO_EN && m_hcnt == HOLD_MAX - 1) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_pre   = 1'b1;
    end else begin
      m_hcnt++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] exp_gnt;
    exp_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, ".sel"}, 32'(sel), 32'(m_sel));
    chk({tag, ".busy"}, 32'(busy), 32'(m_owner >= 0));
    chk({tag, ".preempt"}, 32'(preempt), 32'(m_pre));
    chk({tag, ".onehot"}, 32'($countones(gnt) <= 1), 32'd1);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step(req);
    #1;
    check_model(tag);
  endtask

  // Reset asserted in the middle of a clock cycle must clear outputs at once
  task automatic mid_reset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    chk({tag, ".gnt0"}, 32'(gnt), 32'd0);
    chk({tag, ".sel0"}, 32'(sel), 32'd0);
    chk({tag, ".busy0"}, 32'(busy), 32'd0);
    model_reset();
    check_model(tag);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         order[$];
    int         rot_exp[5];
    int         hold_c;
    int         idle_run;
    int         run;
    logic [3:0] r;
    bit         held;
    bit         pre_seen;

    rot_exp = '{0, 1, 2, 3, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_model("reset");
    #2;
    rst = 1'b0;

    // Grant to 2, then asynchronous reset mid-grant
    req = 4'b0100;
    tick("pre_rst_grant");
    chk("pre_rst_gnt2", 32'(gnt), 32'b0100);
    tick("pre_rst_hold");
    mid_reset("rst_mid");
    req = 4'b1000;
    tick("post_rst");
    chk("post_rst_gnt", 32'(gnt), 32'b1000);
    chk("post_rst_sel", 32'(sel), 32'd3);
    req = 4'b0000;
    tick("post_rst_rel");

    // Rotation with all four requesting; each owner drops after 2 cycles
    r        = 4'b1111;
    hold_c   = 0;
    idle_run = 0;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      req = r;
      tick("rotate");
      if (gnt != 4'b0000) begin
        if (hold_c == 0) begin
          if (order.size() > 0) chk("rot_gap", 32'(idle_run), 32'd1);
          order.push_back(int'(sel));
        end
        hold_c++;
        idle_run = 0;
        if (hold_c == 2) r[sel] = 1'b0;
      end else begin
        hold_c = 0;
        idle_run++;
        r = 4'b1111;
      end
    end
    chk("rot_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < order.size() && i < 5; i++)
      chk("rot_order", 32'(order[i]), 32'(rot_exp[i]));
    req = 4'b0000;
    tick("rot_end");

    // Pointer wrap: owner 3 releases, next grant goes to 0
    req = 4'b0100;
    tick("wrap_g2");
    req = 4'b0000;
    tick("wrap_r2");
    req = 4'b1001;
    tick("wrap_g3");
    chk("wrap_gnt3", 32'(gnt), 32'b1000);
    req = 4'b0001;
    tick("wrap_r3");
    chk("wrap_idle", 32'(gnt), 32'd0);
    req = 4'b1001;
    tick("wrap_g0");
    chk("wrap_gnt0", 32'(gnt), 32'b0001);
    chk("wrap_sel0", 32'(sel), 32'd0);
    req = 4'b0000;
    tick("wrap_end");

    // Skip idle requesters from ptr=1; others raising req do not disturb the grant
    req = 4'b0100;
    tick("skip_g2");
    chk("skip_gnt2", 32'(gnt), 32'b0100);
    chk("skip_sel2", 32'(sel), 32'd2);
    req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick("skip_hold");
      chk("skip_hold_gnt", 32'(gnt), 32'b0100);
    end
    req = 4'b1011;
    tick("skip_rel");
    chk("skip_rel_gnt", 32'(gnt), 32'd0);
    tick("skip_next");
    chk("skip_next_gnt", 32'(gnt), 32'b1000);
    req = 4'b0000;
    tick("skip_end");

    // Move ptr to 1, then requester 1 holds while requester 3 waits
    req = 4'b0001;
    tick("to_setup_g");
    req = 4'b0000;
    tick("to_setup_r");
    req = 4'b1010;
    tick("to_grant");
    chk("to_gnt1", 32'(gnt), 32'b0010);
`ifdef ARB_TIMEOUT_EN
    run = 1;
    for (int c = 0; c < 40; c++) begin
      tick("to_hold");
      if (gnt !== 4'b0010) break;
      run++;
    end
    chk("to_len", 32'(run), 32'd8);
    chk("to_rel_gnt", 32'(gnt), 32'd0);
    chk("to_preempt", 32'(preempt), 32'd1);
    tick("to_next");
    chk("to_next_gnt", 32'(gnt), 32'b1000);
    chk("to_preempt_low", 32'(preempt), 32'd0);
`else
    held     = 1'b1;
    pre_seen = 1'b0;
    run      = 0;
    for (int c = 0; c < 20; c++) begin
      tick("nto_hold");
      held     = held & (gnt === 4'b0010);
      pre_seen = pre_seen | (preempt === 1'b1);
      run++;
    end
    chk("nto_held", 32'(held), 32'd1);
    chk("nto_preempt", 32'(pre_seen), 32'd0);
    chk("nto_cycles", 32'(run), 32'd20);
`endif
    req = 4'b0000;
    tick("to_end0");
    tick("to_end1");

    // Random traffic checked cycle by cycle against the model
    for (int c = 0; c < 400; c++) begin
      if (c == 200) mid_reset("rand_rst");
      if ($urandom_range(0, 2) == 0) req = 4'($urandom_range(0, 15));
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
